u64_to_f32_pipe: RTL
====================

U64_TO_F32_PIPE -- requirements
Module: u64_to_f32_pipe

Interface
REQ-001 SHALL have parameter TAG_W, default 8, the width of the sideband tag carried alongside each sample.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, input sample present.
REQ-005 SHALL have port in_ready, output, 1, block accepts the input this cycle.
REQ-006 SHALL have port in_data, input, 64, unsigned integer (TOF/correlation accumulator).
REQ-007 SHALL have port in_tag, input, TAG_W, opaque sideband passed through unchanged.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result this cycle.
REQ-010 SHALL have port out_data, output, 32, IEEE-754 single-precision encoding of in_data.
REQ-011 SHALL have port out_tag, output, TAG_W, tag of the sample in out_data.

Function
REQ-012 SHALL be a 3-stage pipeline: S1 registers the sample with its leading-zero count lz (6 b) and zero flag; S2 registers the normalized value n = x << lz and biased exponent e = 190 - lz; S3 registers the rounded result.
REQ-013 SHALL use a global advance = !out_valid | out_ready; each stage loads only when advance is 1; in_ready = advance.
REQ-014 SHALL accept a transfer on in_valid & in_ready and present it on out_valid exactly 3 cycles later when advance stays 1 throughout.
REQ-015 SHALL keep a per-stage valid bit; a bubble (in_valid=0 while advancing) propagates as valid=0; no sample is dropped or duplicated under any out_ready pattern.
REQ-016 SHALL hold out_data/out_tag stable while out_valid=1 and out_ready=0.
REQ-017 SHALL form mantissa m = n[62:40] (23 b), guard g = n[39], sticky s = OR(n[38:0]), lsb l = n[40].
REQ-018 SHALL round to nearest, ties to even: increment m when g & (s | l).
REQ-019 SHALL, when the increment carries out of 23 bits, set mantissa to 0 and exponent to e+1 (max 191, never Inf).
REQ-020 SHALL output sign bit 0 always; out_data = {1'b0, exponent[7:0], mantissa[22:0]}.
REQ-021 SHALL output 32'h0000_0000 for in_data = 0 (zero flag overrides exponent/mantissa).
REQ-022 SHALL be exact (no rounding) for in_data < 2^24.
REQ-023 SHALL accept a new input in the same cycle that S3 output is consumed (full throughput, 1 sample/cycle).

Reset
REQ-024 SHALL on rst clear all stage valid bits, out_data to 0 and out_tag to 0, asynchronously.
REQ-025 SHALL discard all in-flight samples on reset mid-operation; out_valid=0 from reset assertion until 3 cycles after the first post-reset accept.
REQ-026 SHALL drive in_ready=1 while reset is deasserted and the pipeline is empty.

Structure
REQ-027 SHALL place F32_BIAS (127), MANT_W (23), EXP_W (8) and the packed f32 struct type in the shared project package.
REQ-028 SHALL instantiate the existing clz64 combinational counter in S1 for lz; no other sub-module.
REQ-029 SHALL keep datapath registers without reset; only valid bits and output registers are reset.

Verification
REQ-030 SHALL cover: in_data=1 -> 32'h3F80_0000; in_data=0 -> 32'h0000_0000, 3 cycles after accept.
REQ-031 SHALL cover: in_data=64'hFFFF_FFFF_FFFF_FFFF -> 32'h5F80_0000 (rounding carry into exponent).
REQ-032 SHALL cover: in_data=0x100_0001 -> 32'h4B80_0000 (tie to even, down); 0x100_0003 -> 32'h4B80_0002 (tie, up).
REQ-033 SHALL cover: stream 8 tagged samples with out_ready low for 5 cycles mid-stream -> in_ready low during the stall, all 8 results in order with matching tags, output stable while stalled.
REQ-034 SHALL cover: assert rst with 3 samples in flight -> out_valid=0 immediately, none of the 3 emerge; next accepted sample emerges after 3 cycles.
REQ-035 SHALL cover: random 64-bit stream with random out_ready against a reference model of the f32 conversion -> bit-exact match, no loss/duplication.

Source files
------------

// File: rtl/u64_to_f32_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | u64_to_f32_pipe_pkg                                                  |
// | Shared f32 field widths, bias and packed result type.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package u64_to_f32_pipe_pkg;

  localparam int F32_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;
  localparam int IN_W     = 64;
  localparam int LZ_W     = 6;

  // Exponent of a value whose MSB sits at bit 63, before subtracting lz.
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(F32_BIAS + IN_W - 1);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } f32_t;

endpackage
`default_nettype wire

// File: rtl/clz64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clz64                                                                |
// | Combinational leading-zero count of a 64-bit word (63 for zero).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module clz64 (
  input  logic [63:0] data_i,
  output logic [5:0]  lz_o
);

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    lz_o = 6'd63;
    for (int i = 0; i < 64; i++) begin
      if (data_i[i]) lz_o = 6'(63 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/u64_to_f32_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | u64_to_f32_pipe                                                      |
// | 3-stage unsigned 64-bit to IEEE-754 single conversion, RNE rounding. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module u64_to_f32_pipe
  import u64_to_f32_pipe_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic             advance;
  logic [LZ_W-1:0]  lz_w;

  logic             s1_valid_q, s2_valid_q, s3_valid_q;
  logic [IN_W-1:0]  s1_x_q;
  logic [LZ_W-1:0]  s1_lz_q;
  logic             s1_zero_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic [IN_W-1:0]  s2_n_d, s2_n_q;
  logic [EXP_W-1:0] s2_e_d, s2_e_q;
  logic             s2_zero_q;
  logic [TAG_W-1:0] s2_tag_q;

  f32_t             res_d, out_data_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [MANT_W-1:0] mant_w, mant_r_w;
  logic              guard_w, sticky_w, lsb_w, round_up_w, carry_w;

  assign advance   = !s3_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

  clz64 u_clz64 (
    .data_i (in_data),
    .lz_o   (lz_w)
  );

  assign s2_n_d = s1_x_q << s1_lz_q;
  assign s2_e_d = EXP_TOP - {2'b00, s1_lz_q};

  assign mant_w     = s2_n_q[62:40];
  assign guard_w    = s2_n_q[39];
  assign sticky_w   = |s2_n_q[38:0];
  assign lsb_w      = s2_n_q[40];
  assign round_up_w = guard_w & (sticky_w | lsb_w);
  assign {carry_w, mant_r_w} = {1'b0, mant_w} + {{MANT_W{1'b0}}, round_up_w};

  // Bit 63 of n is the hidden one; its absence is a second sign of zero input.
  always_comb begin
    res_d      = '0;
    res_d.sign = 1'b0;
    res_d.exp  = carry_w ? s2_e_q + 8'd1 : s2_e_q;
    res_d.mant = carry_w ? '0 : mant_r_w;
    if (s2_zero_q || !s2_n_q[63]) res_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      out_data_q <= res_d;
      out_tag_q  <= s2_tag_q;
    end
  end

  // Datapath registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_x_q    <= in_data;
      s1_lz_q   <= lz_w;
      s1_zero_q <= (in_data == 64'd0);
      s1_tag_q  <= in_tag;
      s2_n_q    <= s2_n_d;
      s2_e_q    <= s2_e_d;
      s2_zero_q <= s1_zero_q;
      s2_tag_q  <= s1_tag_q;
    end
  end

endmodule
`default_nettype wire
